// File: rtl/cheri_dmem_responder.sv
// -----------------------------------------------------------------------------
// cheri_dmem_responder
//
// Memory-side responder for the CHERIoT core data port. It accepts req/gnt
// transactions against a word-addressed 32-bit data array plus a separate
// per-word capability tag. Each access is performed when it is accepted.
// The response (rvalid/rdata/err) appears a fixed Latency cycles later.
// At most one request is outstanding. A new request may be accepted in the
// cycle its predecessor responds, which gives back-to-back throughput.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   gnt_stall_i           back-pressure: forces data_gnt_o low
//   data_req_i/gnt_o      request handshake
//   data_we_i             1 = write
//   data_is_cap_i         capability access (needs data_be_i == 4'hf)
//   data_be_i             byte enables
//   data_addr_i           byte address, bits [1:0] ignored
//   data_wdata_i          write data, bit 32 = capability tag
//   data_wdata_intg_i     unused
//   data_rvalid_o         one-cycle response strobe
//   data_rdata_o          read data {tag, word}, valid with rvalid
//   data_rdata_intg_o     tied to zero
//   data_err_o            access error, valid with rvalid
// -----------------------------------------------------------------------------
module cheri_dmem_responder #(
   parameter int          DataWidth = 33,
   parameter logic [31:0] MemBase   = 32'h2000_0000,
   parameter int          MemDepth  = 4096,
   parameter int          Latency   = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 gnt_stall_i,
   input  logic                 data_req_i,
   output logic                 data_gnt_o,
   input  logic                 data_we_i,
   input  logic                 data_is_cap_i,
   input  logic [3:0]           data_be_i,
   input  logic [31:0]          data_addr_i,
   input  logic [DataWidth-1:0] data_wdata_i,
   input  logic [6:0]           data_wdata_intg_i,
   output logic                 data_rvalid_o,
   output logic [DataWidth-1:0] data_rdata_o,
   output logic [6:0]           data_rdata_intg_o,
   output logic                 data_err_o
);

   localparam int          IdxW     = $clog2(MemDepth);
   // Range checks are done in 33 bits so MemBase + 4*MemDepth cannot wrap.
   localparam logic [32:0] MemLo    = {1'b0, MemBase};
   localparam logic [32:0] MemHi    = MemLo + 33'(4 * MemDepth);
   localparam logic [3:0]  CntLoad  = 4'(Latency - 1);

   logic                 busy_q;
   logic [3:0]           cnt_q;
   logic                 err_q;
   logic [DataWidth-1:0] rdata_q;
   logic [MemDepth-1:0]  tag_q;
   logic [31:0]          mem [MemDepth];

   logic                 rsp_now;
   logic                 accept;
   logic [32:0]          addr_x;
   logic [32:0]          offset;
   logic                 in_range;
   logic                 access_err;
   logic [IdxW-1:0]      idx;
   logic                 unused_intg;

   assign unused_intg = ^data_wdata_intg_i;

   // The response cycle also frees the slot, so a request may be granted
   // in the same cycle the previous one responds.
   assign rsp_now    = busy_q && (cnt_q == 4'd0);
   assign data_gnt_o = data_req_i & ~gnt_stall_i & (~busy_q | rsp_now);
   assign accept     = data_req_i & data_gnt_o;

   // Address decode and error classification for the request on the bus.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a value on every
      // path through the block; otherwise synthesis infers a latch.
      addr_x     = {1'b0, data_addr_i};
      offset     = addr_x - MemLo;
      in_range   = (addr_x >= MemLo) && (addr_x < MemHi);
      idx        = IdxW'(offset >> 2);
      access_err = ~in_range | (data_is_cap_i & (data_be_i != 4'hf));
   end

   // Data array: byte-enabled writes, committed on the accept edge.
   // NOTE: the data array has no reset; it maps onto block RAM and only the
   // tags must be known-clear after reset.
   always_ff @(posedge clk_i) begin
      if (accept && !access_err && data_we_i && !rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Control, tag array and response registers.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      if (rst_i) begin
         busy_q  <= 1'b0;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         tag_q   <= '0;
      end else begin
         if (accept) begin
            busy_q <= 1'b1;
            cnt_q  <= CntLoad;
            if (access_err) begin
               err_q   <= 1'b1;
               rdata_q <= '0;
            end else if (data_we_i) begin
               // A plain data write always invalidates the capability,
               // even when no byte is enabled.
               tag_q[idx] <= data_is_cap_i ? data_wdata_i[32] : 1'b0;
               err_q      <= 1'b0;
               rdata_q    <= '0;
            end else begin
               // Read data is captured now, so later writes cannot
               // disturb a pending response.
               err_q   <= 1'b0;
               rdata_q <= {tag_q[idx], mem[idx]};
            end
         end else if (rsp_now) begin
            busy_q <= 1'b0;
         end else if (busy_q && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   assign data_rvalid_o     = rsp_now;
   assign data_rdata_o      = rdata_q;
   assign data_err_o        = err_q & rsp_now;
   assign data_rdata_intg_o = 7'h0;

endmodule

// File: doc/cheri_dmem_responder.md
# cheri_dmem_responder

Memory-side responder for the CHERIoT core's data memory interface: it accepts req/gnt transactions, keeps a word-addressed data array with a separate per-word capability tag array, and returns rvalid, rdata and err after a fixed latency. It sits opposite the core wrapper's data port in simulation benches and small FPGA images. It replaces a generic SRAM model so that bench scenarios cover tag clearing, capability accesses and grant back-pressure.

## Interface
- DataWidth, 33, word width; bit 32 is the capability tag
- MemBase, 32'h2000_0000, byte address of word 0
- MemDepth, 4096, number of words; power of two
- Latency, 1, cycles from accept edge to rvalid; legal range 1..15
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- gnt_stall_i  in  1  bench back-pressure; 1 forces data_gnt_o low
- data_req_i  in  1  request valid
- data_gnt_o  out  1  request accepted this cycle
- data_we_i  in  1  1 = write
- data_is_cap_i  in  1  capability access
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  DataWidth  write data
- data_wdata_intg_i  in  7  ignored
- data_rvalid_o  out  1  response valid, one cycle per accepted request
- data_rdata_o  out  DataWidth  read data, valid with rvalid
- data_rdata_intg_o  out  7  tied 7'h0
- data_err_i is not an input here; data_err_o  out  1  error, valid with rvalid

## Operation
- State: busy_q, cnt_q[3:0], err_q, rdata_q; tag_q[MemDepth-1:0]; data array mem[MemDepth] x 32 bits, not reset.
- data_gnt_o = data_req_i & ~gnt_stall_i & (~busy_q | rsp_now), with rsp_now = busy_q & (cnt_q == 0).
- Accept = data_req_i & data_gnt_o. On the accept edge: busy_q<=1, cnt_q<=Latency-1, and the access is decoded and performed.
- Index = (data_addr_i - MemBase) >> 2; in_range = data_addr_i >= MemBase and data_addr_i < MemBase + 4*MemDepth, compared in 33-bit arithmetic. data_addr_i[1:0] is ignored.
- Error cases, each setting err_q<=1 with rdata_q<=0 and no array update:
  - not in_range;
  - data_is_cap_i=1 with data_be_i != 4'hf.
- Non-cap write: write the enabled bytes and clear tag_q[idx]. This applies even if data_be_i=0.
- Cap write: mem[idx]<=wdata[31:0] and tag_q[idx]<=wdata[32].
- Read, cap or non-cap: rdata_q<={tag_q[idx], mem[idx]} and err_q<=0. Read data is captured at the accept edge, so a later write does not change a pending response.
- Write response: rdata_q<=0 and err_q<=0.
- While busy_q & cnt_q != 0: cnt_q decrements.
- data_rvalid_o = rsp_now. data_rdata_o = rdata_q. data_err_o = err_q & rsp_now.
- rsp_now without a new accept: busy_q<=0.
- rsp_now with a new accept: busy_q stays 1 and the new request loads the state. This gives back-to-back throughput.
- At most one request is outstanding.

## Timing
- Reset: the cycle after rst_i=1 is sampled, all of the following are 0:
  - data_gnt_o (combinational, since busy_q=0 and gated by req);
  - data_rvalid_o, data_err_o, data_rdata_o;
  - busy_q, cnt_q, and every bit of tag_q.
- Reset mid-transaction: the pending response is dropped and no rvalid is produced. A write already performed at its accept edge is not undone.
- Latency=L: a request accepted at edge of cycle A gets rvalid in cycle A+L.
- With Latency=1 and no stall, one transaction completes per cycle.
- With Latency=L>1, the next grant comes no earlier than cycle A+L, so issue rate is 1/L.
- gnt_stall_i=1 in the rvalid cycle: the response still completes, the new request is not granted, and busy_q falls.
- data_req_i may drop without a grant; the responder keeps no state for ungranted requests.
- Read after write to the same word with Latency=1: the read accepted in the write's rvalid cycle returns the new data (the write committed at its accept edge).

## Test plan
- Reset, then write 32'hDEAD_BEEF with be=4'hf, non-cap, to 0x2000_0010, then read 0x2000_0010 -> rvalid exactly 1 cycle after each grant; read data 33'h0_DEAD_BEEF; err=0.
- Cap write of 33'h1_1234_5678 to 0x2000_0020, then a non-cap write of 8'hAA with be=4'b0001, then a cap read -> 33'h0_1234_56AA (tag cleared).
- Cap write to 0x2000_0030 with be=4'b0011 -> err=1 with rvalid; a following read of 0x2000_0030 returns the unchanged prior contents.
- Read at 0x1FFF_FFFC and at MemBase+4*MemDepth -> err=1, rdata=0. Write to 0x2000_3FFC -> err=0.
- Latency=3: 4 back-to-back reads with gnt_stall_i toggling each cycle -> exactly 4 rvalid pulses, in order, each 3 cycles after its grant, never 2 outstanding.
- Cap-write a tagged word, assert rst_i for one cycle while a read is pending -> no rvalid for that read; the word reads back with tag=0 and its data intact.
